// File: rtl/alarm_clock_multi_pkg.sv
// Shared types and helpers for the multi-slot alarm clock.
package alarm_clock_multi_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} ring_t;

  localparam int unsigned TW = 7;

  // Increment with wrap at modulus m (m <= 128).
  function automatic logic [TW-1:0] inc_mod(input logic [TW-1:0] v, input int unsigned m);
    return (v == TW'(m - 1)) ? '0 : v + TW'(1);
  endfunction

endpackage

// File: rtl/alarm_clock_multi_slot.sv
// One alarm slot: minute/hour setting, trigger match and ring/snooze FSM.
module alarm_slot
  import alarm_clock_multi_pkg::*;
#(
  parameter int unsigned NS   = 60,
  parameter int unsigned NM   = 60,
  parameter int unsigned NH   = 24,
  parameter int unsigned ND   = 7,
  parameter int unsigned SNZ  = 5,
  parameter int unsigned RMAX = 60,
  localparam int unsigned DW  = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic          i_set_en,
  input  logic          i_minadv,
  input  logic          i_hrsadv,
  input  logic          i_wrap,
  input  logic [TW-1:0] i_cur_min,
  input  logic [TW-1:0] i_cur_hrs,
  input  logic [DW-1:0] i_cur_day,
  input  logic [ND-1:0] i_day_mask,
  input  logic          i_alarm_on,
  input  logic          i_snooze,
  input  logic          i_stop,
  output logic [TW-1:0] o_amin,
  output logic [TW-1:0] o_ahrs,
  output logic          o_buzz
);

  localparam int unsigned SW = $clog2(SNZ * NS + 1);
  localparam int unsigned RW = $clog2(RMAX + 1);

  logic [TW-1:0] r_amin, r_ahrs;
  ring_t         r_state, w_state_next;
  logic [RW-1:0] r_timer, w_timer_next;
  logic [SW-1:0] r_snz, w_snz_next;
  logic          w_trig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_amin <= '0;
      r_ahrs <= '0;
    end else if (i_set_en && i_tick) begin
      if (i_minadv) r_amin <= inc_mod(r_amin, NM);
      if (i_hrsadv) r_ahrs <= inc_mod(r_ahrs, NH);
    end
  end

  assign w_trig = i_wrap && (i_cur_min == r_amin) && (i_cur_hrs == r_ahrs) && i_day_mask[i_cur_day];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_snz   <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_snz   <= w_snz_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_snz_next   = r_snz;
    if (!i_alarm_on) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_trig) begin
          w_state_next = RING;
          w_timer_next = RW'(RMAX);
        end
        RING: if (i_stop) begin
          w_state_next = IDLE;
        end else if (i_snooze) begin
          w_state_next = SNOOZE;
          w_snz_next   = SW'(SNZ * NS);
        end else if (i_tick) begin
          w_timer_next = (r_timer == '0) ? '0 : r_timer - RW'(1);
          if (r_timer <= RW'(1)) w_state_next = IDLE;
        end
        SNOOZE: if (i_stop) begin
          w_state_next = IDLE;
        end else if (i_tick) begin
          w_snz_next = (r_snz == '0) ? '0 : r_snz - SW'(1);
          if (r_snz <= SW'(1)) begin
            w_state_next = RING;
            w_timer_next = RW'(RMAX);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_amin = r_amin;
  assign o_ahrs = r_ahrs;
  assign o_buzz = (r_state == RING);

endmodule

// File: rtl/alarm_clock_multi.sv
// Time-of-day/day-of-week clock with mode FSM and NA independent alarm slots.
module alarm_clock_multi
  import alarm_clock_multi_pkg::*;
#(
  parameter int unsigned NS   = 60,
  parameter int unsigned NM   = 60,
  parameter int unsigned NH   = 24,
  parameter int unsigned ND   = 7,
  parameter int unsigned NA   = 4,
  parameter int unsigned SNZ  = 5,
  parameter int unsigned RMAX = 60,
  localparam int unsigned AW  = (NA > 1) ? $clog2(NA) : 1,
  localparam int unsigned DW  = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             timeset,
  input  logic             alarmset,
  input  logic             minadv,
  input  logic             hrsadv,
  input  logic             dysadv,
  input  logic [AW-1:0]    asel,
  input  logic [NA-1:0]    alarm_on,
  input  logic [NA*ND-1:0] day_mask,
  input  logic             snooze,
  input  logic             stop,
  output logic [TW-1:0]    tsec,
  output logic [TW-1:0]    tmin,
  output logic [TW-1:0]    thrs,
  output logic [DW-1:0]    tdys,
  output logic [TW-1:0]    dmin,
  output logic [TW-1:0]    dhrs,
  output logic [NA-1:0]    buzz,
  output logic             buzz_any,
  output logic [1:0]       mode
);

  generate
    if (NS > 128 || NM > 128 || NH > 128 || ND > 128) begin : g_bad_modulus
      $error("alarm_clock_multi: NS/NM/NH/ND must not exceed 128");
    end
    if (NA < 1 || NA > 8) begin : g_bad_slots
      $error("alarm_clock_multi: NA must be in 1..8");
    end
  endgenerate

  mode_t         r_mode, w_mode_next;
  logic [TW-1:0] r_sec, r_min, r_hrs;
  logic [DW-1:0] r_dys;
  logic [TW-1:0] w_sec_next, w_min_next, w_hrs_next;
  logic [DW-1:0] w_dys_next;
  logic          w_wrap;
  logic [TW-1:0] w_amin [NA];
  logic [TW-1:0] w_ahrs [NA];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mode <= RUN;
    else      r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = RUN;
    if (timeset)       w_mode_next = SET_TIME;
    else if (alarmset) w_mode_next = SET_ALARM;
  end

  // Next time is also the post-increment time the slots match against.
  always_comb begin
    w_sec_next = r_sec;
    w_min_next = r_min;
    w_hrs_next = r_hrs;
    w_dys_next = r_dys;
    w_wrap     = 1'b0;
    if (tick) begin
      if (r_mode == SET_TIME) begin
        if (minadv) w_min_next = inc_mod(r_min, NM);
        if (hrsadv) w_hrs_next = inc_mod(r_hrs, NH);
        if (dysadv) w_dys_next = DW'(inc_mod(TW'(r_dys), ND));
      end else begin
        w_sec_next = inc_mod(r_sec, NS);
        if (r_sec == TW'(NS - 1)) begin
          w_wrap     = (r_mode == RUN);
          w_min_next = inc_mod(r_min, NM);
          if (r_min == TW'(NM - 1)) begin
            w_hrs_next = inc_mod(r_hrs, NH);
            if (r_hrs == TW'(NH - 1)) w_dys_next = DW'(inc_mod(TW'(r_dys), ND));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec <= '0;
      r_min <= '0;
      r_hrs <= '0;
      r_dys <= '0;
    end else begin
      r_sec <= w_sec_next;
      r_min <= w_min_next;
      r_hrs <= w_hrs_next;
      r_dys <= w_dys_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_slot
      alarm_slot #(
        .NS(NS), .NM(NM), .NH(NH), .ND(ND), .SNZ(SNZ), .RMAX(RMAX)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick),
        .i_set_en   ((r_mode == SET_ALARM) && (asel == AW'(gi))),
        .i_minadv   (minadv),
        .i_hrsadv   (hrsadv),
        .i_wrap     (w_wrap),
        .i_cur_min  (w_min_next),
        .i_cur_hrs  (w_hrs_next),
        .i_cur_day  (w_dys_next),
        .i_day_mask (day_mask[gi*ND +: ND]),
        .i_alarm_on (alarm_on[gi]),
        .i_snooze   (snooze),
        .i_stop     (stop),
        .o_amin     (w_amin[gi]),
        .o_ahrs     (w_ahrs[gi]),
        .o_buzz     (buzz[gi])
      );
    end
  endgenerate

  assign tsec     = r_sec;
  assign tmin     = r_min;
  assign thrs     = r_hrs;
  assign tdys     = r_dys;
  assign dmin     = (r_mode == SET_ALARM) ? w_amin[asel] : r_min;
  assign dhrs     = (r_mode == SET_ALARM) ? w_ahrs[asel] : r_hrs;
  assign buzz_any = |buzz;
  assign mode     = r_mode;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi: rollover, setting, ringing, snooze/stop and async reset.
module tb_alarm_clock_multi;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst;
  logic        tick, timeset, alarmset, minadv, hrsadv, dysadv;
  logic [1:0]  asel;
  logic [3:0]  alarm_on;
  logic [27:0] day_mask;
  logic        snooze, stop;
  logic [6:0]  tsec, tmin, thrs, dmin, dhrs;
  logic [2:0]  tdys;
  logic [3:0]  buzz;
  logic        buzz_any;
  logic [1:0]  mode;

  int n_cmp = 0;
  int n_err = 0;

  alarm_clock_multi dut (
    .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .dysadv(dysadv), .asel(asel),
    .alarm_on(alarm_on), .day_mask(day_mask), .snooze(snooze), .stop(stop),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .tdys(tdys), .dmin(dmin), .dhrs(dhrs),
    .buzz(buzz), .buzz_any(buzz_any), .mode(mode)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // n ticks; each button held for the first nm/nh/nd of them
  task automatic adv_ticks(input int n, input int nm, input int nh, input int nd);
    for (int i = 0; i < n; i++) begin
      minadv = (i < nm);
      hrsadv = (i < nh);
      dysadv = (i < nd);
      ticks(1);
    end
    minadv = 1'b0;
    hrsadv = 1'b0;
    dysadv = 1'b0;
  endtask

  task automatic set_mode(input logic ts, input logic as);
    timeset  = ts;
    alarmset = as;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; tick = 0; timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0; dysadv = 0;
    asel = 2'd0; alarm_on = 4'b0000; day_mask = 28'h0; snooze = 0; stop = 0;
    repeat (3) @(negedge clk);
    chk("rst_tsec", 32'(tsec), 0);
    chk("rst_tmin", 32'(tmin), 0);
    chk("rst_thrs", 32'(thrs), 0);
    chk("rst_tdys", 32'(tdys), 0);
    chk("rst_dmin", 32'(dmin), 0);
    chk("rst_buzz", 32'(buzz), 0);
    chk("rst_buzz_any", 32'(buzz_any), 0);
    chk("rst_mode", 32'(mode), 0);
    rst = 1'b1;
    @(negedge clk);

    // Both mode buttons: time-set wins
    set_mode(1'b1, 1'b1);
    chk("mode_priority", 32'(mode), 1);
    alarmset = 1'b0;
    adv_ticks(59, 59, 23, 6);
    chk("set_tmin59", 32'(tmin), 59);
    chk("set_thrs23", 32'(thrs), 23);
    chk("set_tdys6", 32'(tdys), 6);
    chk("set_tsec_held", 32'(tsec), 0);
    set_mode(1'b0, 1'b0);
    chk("mode_run", 32'(mode), 0);
    ticks(59);
    chk("pre_roll_tsec", 32'(tsec), 59);
    ticks(1);
    chk("roll_tsec", 32'(tsec), 0);
    chk("roll_tmin", 32'(tmin), 0);
    chk("roll_thrs", 32'(thrs), 0);
    chk("roll_tdys", 32'(tdys), 0);

    // SET_TIME: seconds frozen, minute wrap without hour carry
    ticks(17);
    chk("run_tsec17", 32'(tsec), 17);
    set_mode(1'b1, 1'b0);
    adv_ticks(58, 58, 0, 0);
    chk("st_tmin58", 32'(tmin), 58);
    adv_ticks(3, 3, 0, 0);
    chk("st_tmin1", 32'(tmin), 1);
    chk("st_thrs0", 32'(thrs), 0);
    chk("st_tsec17", 32'(tsec), 17);

    // Program slot 1 then slot 0 to 07:30 while time keeps running
    asel = 2'd1;
    set_mode(1'b0, 1'b1);
    chk("mode_set_alarm", 32'(mode), 2);
    adv_ticks(30, 30, 7, 0);
    chk("sa1_dmin", 32'(dmin), 30);
    chk("sa1_dhrs", 32'(dhrs), 7);
    chk("sa_tsec47", 32'(tsec), 47);
    chk("sa_tmin1", 32'(tmin), 1);
    asel = 2'd0;
    @(negedge clk);
    chk("sa0_dmin_init", 32'(dmin), 0);
    adv_ticks(30, 30, 7, 1);
    chk("sa0_dmin", 32'(dmin), 30);
    chk("sa0_dhrs", 32'(dhrs), 7);
    chk("sa_tsec17", 32'(tsec), 17);
    chk("sa_tmin2", 32'(tmin), 2);
    chk("sa_tdys_ignored", 32'(tdys), 0);

    // Mon 07:29:59 -> ring on slot 1
    set_mode(1'b1, 1'b0);
    chk("st_dmin_live", 32'(dmin), 2);
    adv_ticks(27, 27, 7, 0);
    chk("st_thrs7", 32'(thrs), 7);
    alarm_on = 4'b0010;
    day_mask = 28'h0000080;
    set_mode(1'b0, 1'b0);
    ticks(42);
    chk("pre_ring_tsec", 32'(tsec), 59);
    chk("pre_ring_buzz", 32'(buzz), 0);
    ticks(1);
    chk("ring_tmin30", 32'(tmin), 30);
    chk("ring_buzz", 32'(buzz), 4'b0010);
    chk("ring_buzz_any", 32'(buzz_any), 1);

    // Snooze 300 ticks, ring again, then 60-tick timeout
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    chk("snz_buzz0", 32'(buzz), 0);
    ticks(299);
    chk("snz_299", 32'(buzz), 0);
    ticks(1);
    chk("snz_300", 32'(buzz), 4'b0010);
    ticks(59);
    chk("rmax_59", 32'(buzz), 4'b0010);
    ticks(1);
    chk("rmax_60", 32'(buzz), 0);

    // Same time on Tuesday: masked off
    set_mode(1'b1, 1'b0);
    adv_ticks(53, 53, 0, 1);
    chk("tue_tmin29", 32'(tmin), 29);
    chk("tue_tdys1", 32'(tdys), 1);
    set_mode(1'b0, 1'b0);
    ticks(60);
    chk("tue_tmin30", 32'(tmin), 30);
    chk("tue_no_buzz", 32'(buzz), 0);

    // Enable Tuesday; snooze and stop together -> idle
    day_mask = 28'h0000180;
    set_mode(1'b1, 1'b0);
    adv_ticks(59, 59, 0, 0);
    set_mode(1'b0, 1'b0);
    ticks(60);
    chk("tue_ring", 32'(buzz), 4'b0010);
    snooze = 1'b1;
    stop   = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    stop   = 1'b0;
    chk("snzstop_buzz", 32'(buzz), 0);
    ticks(300);
    chk("snzstop_idle", 32'(buzz), 0);

    // Two slots ring; dropping alarm_on[1] silences only slot 1
    alarm_on = 4'b0011;
    day_mask = 28'h0000182;
    set_mode(1'b1, 1'b0);
    adv_ticks(54, 54, 0, 0);
    set_mode(1'b0, 1'b0);
    ticks(60);
    chk("dual_ring", 32'(buzz), 4'b0011);
    alarm_on = 4'b0001;
    @(negedge clk);
    chk("drop_on1", 32'(buzz), 4'b0001);
    chk("drop_buzz_any", 32'(buzz_any), 1);

    // Reset mid-snooze with the clock stopped
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    ticks(5);
    chk("pre_rst_tsec", 32'(tsec), 5);
    clk_run = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tsec", 32'(tsec), 0);
    chk("arst_tmin", 32'(tmin), 0);
    chk("arst_thrs", 32'(thrs), 0);
    chk("arst_tdys", 32'(tdys), 0);
    chk("arst_dmin", 32'(dmin), 0);
    chk("arst_dhrs", 32'(dhrs), 0);
    chk("arst_buzz", 32'(buzz), 0);
    chk("arst_mode", 32'(mode), 0);
    #10;
    rst = 1'b1;
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_buzz", 32'(buzz), 0);
    ticks(300);
    chk("post_rst_no_resume", 32'(buzz), 0);
    chk("post_rst_tmin", 32'(tmin), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
